ram_bank_clr: RTL and testbench

//  Parametrised single-port synchronous RAM for the CPU memory map; successor to the fixed 256x16 block.

---
 rtl/ram_bank_clr.sv | 80 ++++++++
 tb/tb_ram_bank_clr.sv | 119 +++++++++++
 2 files changed

// File: rtl/ram_bank_clr.sv
// ram_bank_clr: parametrised single-port RAM with post-reset clear sweep and busy flag.
// Define RAM_BOUNDS_EN to add the addr_err port and suppress out-of-range accesses.
module ram_bank_clr #(
    parameter int              DATA_W      = 16,
    parameter int              BUS_W       = 16,
    parameter int              ADDR_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
    parameter bit              READ_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              load_bar,
    input  logic [BUS_W-1:0]  address,
    output logic [DATA_W-1:0] value,
`ifdef RAM_BOUNDS_EN
    output logic              addr_err,
`endif
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              busy_q, busy_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              oob;
    logic              ready;
    logic              user_we;
    logic [DATA_W-1:0] rd_word;
    assign idx = address[ADDR_W-1:0];
`ifdef RAM_BOUNDS_EN
    if (ADDR_W < BUS_W) begin : g_oob
        assign oob = |address[BUS_W-1:ADDR_W];
    end else begin : g_no_oob
        assign oob = 1'b0;
    end
    assign addr_err = addr_err_q;
`else
    assign oob = 1'b0;
`endif
    assign ready   = state_q == READY;
    assign user_we = ready && !load_bar && !oob;
    assign rd_word = mem[idx];
    always_comb begin
        state_d    = state_q == READY ? READY : (&clr_ptr_q ? READY : CLEAR);
        clr_ptr_d  = ready ? clr_ptr_q : clr_ptr_q + 1'b1;
        busy_d     = state_d == CLEAR;
        addr_err_d = ready && oob;
        // write-first bypass forwards the incoming word when reading the address being written
        value_d    = !ready || oob ? '0 : (!READ_FIRST && !load_bar) ? in : rd_word;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            value_q    <= '0;
            busy_q     <= 1'b1;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            value_q    <= value_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end
    // array contents survive reset; only the sweep rewrites them
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!ready) mem[clr_ptr_q] <= CLEAR_VALUE;
            else if (user_we) mem[idx] <= in;
        end
    end
    assign value = value_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_ram_bank_clr.sv
// tb_ram_bank_clr: directed checks of clear sweep, read latency, read-during-write and aliasing.
// Runs a READ_FIRST=1 and a READ_FIRST=0 instance side by side on the same stimulus.
module tb_ram_bank_clr;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in = '0;
    logic        load_bar = 1'b1;
    logic [15:0] address = '0;
    logic [15:0] value_rf, value_wf;
    logic        busy_rf, busy_wf;
    int          n_vec = 0;
    int          n_err = 0;
`ifdef RAM_BOUNDS_EN
    logic        err_rf, err_wf;
`endif
    always #5 clk = ~clk;
    ram_bank_clr #(.DATA_W(16), .BUS_W(16), .ADDR_W(4), .CLEAR_VALUE(16'hDEAD), .READ_FIRST(1'b1)) u_rf (
        .clk(clk), .reset(reset), .in(in), .load_bar(load_bar), .address(address),
        .value(value_rf),
`ifdef RAM_BOUNDS_EN
        .addr_err(err_rf),
`endif
        .busy(busy_rf));
    ram_bank_clr #(.DATA_W(16), .BUS_W(16), .ADDR_W(4), .CLEAR_VALUE(16'hDEAD), .READ_FIRST(1'b0)) u_wf (
        .clk(clk), .reset(reset), .in(in), .load_bar(load_bar), .address(address),
        .value(value_wf),
`ifdef RAM_BOUNDS_EN
        .addr_err(err_wf),
`endif
        .busy(busy_wf));
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        tick();
        check("rst_busy", {15'd0, busy_rf}, 16'd1);
        check("rst_value", value_rf, 16'h0000);
`ifdef RAM_BOUNDS_EN
        check("rst_err", {15'd0, err_rf}, 16'd0);
`endif
        reset = 1'b0;
        load_bar = 1'b0; address = 16'd2; in = 16'hFFFF;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("sweep_busy", {15'd0, busy_rf}, i < 16 ? 16'd1 : 16'd0);
            check("sweep_value", value_wf, 16'h0000);
        end
        load_bar = 1'b1;
        for (int i = 0; i < 16; i++) begin
            address = 16'(i);
            tick();
            check("clear_rf", value_rf, 16'hDEAD);
            check("clear_wf", value_wf, 16'hDEAD);
        end
        load_bar = 1'b0; address = 16'd5; in = 16'h1234;
        tick();
        load_bar = 1'b1;
        tick();
        check("wr5_rd", value_rf, 16'h1234);
        load_bar = 1'b0; address = 16'd3; in = 16'h00AA;
        tick();
        in = 16'h5555;
        tick();
        check("rdw_old", value_rf, 16'h00AA);
        check("rdw_new", value_wf, 16'h5555);
        load_bar = 1'b1;
        tick();
        check("rdw_after", value_rf, 16'h5555);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("part_busy", {15'd0, busy_rf}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) check("resweep_busy", {15'd0, busy_wf}, i < 16 ? 16'd1 : 16'd0);
        end
        address = 16'd3;
        tick();
        check("reclr3", value_rf, 16'hDEAD);
        address = 16'd5;
        tick();
        check("reclr5", value_wf, 16'hDEAD);
        load_bar = 1'b0; address = 16'h0013; in = 16'hBEEF;
        tick();
        load_bar = 1'b1;
`ifdef RAM_BOUNDS_EN
        check("oob_err", {15'd0, err_rf}, 16'd1);
        address = 16'h0003;
        tick();
        check("oob_keep", value_rf, 16'hDEAD);
        check("oob_err_clr", {15'd0, err_rf}, 16'd0);
        address = 16'h0013;
        tick();
        check("oob_rd", value_rf, 16'h0000);
        check("oob_err2", {15'd0, err_wf}, 16'd1);
`else
        address = 16'h0003;
        tick();
        check("alias_rd", value_rf, 16'hBEEF);
        address = 16'h00F3;
        tick();
        check("alias_hi", value_wf, 16'hBEEF);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
